// File: rtl/snoop_tag_bank_if.sv
// Bus bundle for snoop_tag_bank: core read/write port, fill port and snoop request/response.
// The master side is the cache controller / coherence agent; the slave side is the tag bank.
interface snoop_tag_bank_if #(
    parameter int TAG_W = 20,
    parameter int LINES = 512,
    parameter int WAYS  = 2
);
    localparam int IDX_W = $clog2(LINES);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int ENT_W = TAG_W + 1;

    logic                    init_done;
    logic                    a_en;
    logic                    a_wen;
    logic [WAY_W-1:0]        a_way;
    logic [IDX_W-1:0]        a_idx;
    logic [ENT_W-1:0]        a_wdata;
    logic [WAYS*ENT_W-1:0]   a_rdata;
    logic                    b_en;
    logic [WAY_W-1:0]        b_way;
    logic [IDX_W-1:0]        b_idx;
    logic [ENT_W-1:0]        b_wdata;
    logic                    snp_valid;
    logic                    snp_ready;
    logic                    snp_inv;
    logic [IDX_W-1:0]        snp_idx;
    logic [TAG_W-1:0]        snp_tag;
    logic                    snp_rsp_valid;
    logic                    snp_hit;
    logic [WAYS-1:0]         snp_hit_way;

    modport master (
        input  init_done, a_rdata, snp_ready, snp_rsp_valid, snp_hit, snp_hit_way,
        output a_en, a_wen, a_way, a_idx, a_wdata,
        output b_en, b_way, b_idx, b_wdata,
        output snp_valid, snp_inv, snp_idx, snp_tag
    );

    modport slave (
        output init_done, a_rdata, snp_ready, snp_rsp_valid, snp_hit, snp_hit_way,
        input  a_en, a_wen, a_way, a_idx, a_wdata,
        input  b_en, b_way, b_idx, b_wdata,
        input  snp_valid, snp_inv, snp_idx, snp_tag
    );
endinterface

// File: rtl/snoop_tag_bank.sv
// Multi-way L1 tag store with core port, fill port, self-clearing sweep and a 2-stage snoop pipeline.
// Optional snoop statistics counters are enabled by defining SNOOP_TAG_BANK_STATS_EN.
module snoop_tag_bank #(
    parameter int TAG_W = 20,
    parameter int LINES = 512,
    parameter int WAYS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    snoop_tag_bank_if.slave   bus
`ifdef SNOOP_TAG_BANK_STATS_EN
    ,
    output logic [31:0]       stat_snp_cnt,
    output logic [31:0]       stat_inv_cnt
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int ENT_W = TAG_W + 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state, state_nxt;
    logic [IDX_W:0]        sweep_cnt, sweep_nxt;
    logic [ENT_W-1:0]      mem [WAYS][LINES];
    logic [WAYS*ENT_W-1:0] a_rdata_q;

    logic                  run, a_wr, b_wr, snp_acc;
    logic                  vld_p1, inv_p1, vld_p2, inv_p2;
    logic [IDX_W-1:0]      idx_p1, idx_p2;
    logic [TAG_W-1:0]      tag_p1, tag_p2;
    logic [ENT_W-1:0]      fwd_p1 [WAYS];
    logic [ENT_W-1:0]      rd_p2 [WAYS];
    logic [WAYS-1:0]       hit_raw, inv_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_nxt;
        end
    end

    // The extra counter bit flags the final index, so RUN starts right after set LINES-1 is cleared.
    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep_cnt;
        case (state)
            ST_INIT: begin
                sweep_nxt = sweep_cnt + 1'b1;
                if (sweep_nxt[IDX_W]) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign run           = (state == ST_RUN);
    assign a_wr          = run & bus.a_en & bus.a_wen;
    assign b_wr          = run & bus.b_en;
    assign bus.init_done = run;
    assign bus.snp_ready = run & ~(vld_p1 & inv_p1);
    assign snp_acc       = bus.snp_valid & bus.snp_ready;

    // S1: read the set and pick up any write landing in the same cycle (fill over core).
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            fwd_p1[w] = mem[w][idx_p1];
            if (a_wr && bus.a_way == WAY_W'(w) && bus.a_idx == idx_p1) fwd_p1[w] = bus.a_wdata;
            if (b_wr && bus.b_way == WAY_W'(w) && bus.b_idx == idx_p1) fwd_p1[w] = bus.b_wdata;
        end
    end

    // S2: compare; an invalidate yields to a core/fill write of the same entry.
    always_comb begin
        hit_raw  = '0;
        inv_take = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_raw[w]  = vld_p2 & rd_p2[w][TAG_W] & (rd_p2[w][TAG_W-1:0] == tag_p2);
            inv_take[w] = inv_p2 & hit_raw[w]
                        & ~(a_wr && bus.a_way == WAY_W'(w) && bus.a_idx == idx_p2)
                        & ~(b_wr && bus.b_way == WAY_W'(w) && bus.b_idx == idx_p2);
        end
    end

    assign bus.snp_rsp_valid = vld_p2;
    assign bus.snp_hit_way   = hit_raw;
    assign bus.snp_hit       = |hit_raw;
    assign bus.a_rdata       = a_rdata_q;

    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (!run) begin
                mem[w][sweep_cnt[IDX_W-1:0]] <= '0;
            end else begin
                if (inv_take[w]) mem[w][idx_p2][TAG_W] <= 1'b0;
                if (a_wr && bus.a_way == WAY_W'(w)) mem[w][bus.a_idx] <= bus.a_wdata;
                if (b_wr && bus.b_way == WAY_W'(w)) mem[w][bus.b_idx] <= bus.b_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata_q <= '0;
            vld_p1    <= 1'b0;
            inv_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            inv_p2    <= 1'b0;
        end else begin
            if (run && bus.a_en && !bus.a_wen) begin
                for (int w = 0; w < WAYS; w++) a_rdata_q[w*ENT_W +: ENT_W] <= mem[w][bus.a_idx];
            end
            vld_p1 <= snp_acc;
            inv_p1 <= snp_acc & bus.snp_inv;
            vld_p2 <= vld_p1;
            inv_p2 <= vld_p1 & inv_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (snp_acc) begin
            idx_p1 <= bus.snp_idx;
            tag_p1 <= bus.snp_tag;
        end
        if (vld_p1) begin
            idx_p2 <= idx_p1;
            tag_p2 <= tag_p1;
            for (int w = 0; w < WAYS; w++) rd_p2[w] <= fwd_p1[w];
        end
    end

`ifdef SNOOP_TAG_BANK_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_snp_cnt <= '0;
            stat_inv_cnt <= '0;
        end else begin
            stat_snp_cnt <= sat_inc(stat_snp_cnt, snp_acc);
            stat_inv_cnt <= sat_inc(stat_inv_cnt, |inv_take);
        end
    end
`endif
endmodule

// File: tb/tb_snoop_tag_bank.sv
// Scoreboard bench for snoop_tag_bank: driver queues expected read/snoop results, a monitor pops and compares.
module tb_snoop_tag_bank;
    localparam int TAG_W = 20;
    localparam int LINES = 512;
    localparam int WAYS  = 2;
    localparam int ENT_W = TAG_W + 1;
    localparam int RD_W  = WAYS * ENT_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snoop_tag_bank_if #(.TAG_W(TAG_W), .LINES(LINES), .WAYS(WAYS)) bus();
`ifdef SNOOP_TAG_BANK_STATS_EN
    logic [31:0] stat_snp_cnt, stat_inv_cnt;
`endif

    snoop_tag_bank #(.TAG_W(TAG_W), .LINES(LINES), .WAYS(WAYS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef SNOOP_TAG_BANK_STATS_EN
        ,
        .stat_snp_cnt(stat_snp_cnt),
        .stat_inv_cnt(stat_inv_cnt)
`endif
    );

    typedef struct {
        logic       hit;
        logic [1:0] way;
        int         cyc;
    } snp_exp_t;

    snp_exp_t          snp_q[$];
    logic [RD_W-1:0]   rd_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a read issued at an edge is compared just after it; snoop pulses pop the snoop queue.
    always @(posedge clk) begin : monitor
        logic rd_take;
        snp_exp_t e;
        rd_take = bus.a_en & ~bus.a_wen;
        cyc++;
        #1;
        if (rd_take) begin
            if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("a_rdata", bus.a_rdata, rd_q.pop_front());
        end
        if (bus.snp_rsp_valid) begin
            if (snp_q.size() == 0) check("snp_rsp_unexpected", 1, 0);
            else begin
                e = snp_q.pop_front();
                check("snp_hit", bus.snp_hit, e.hit);
                check("snp_hit_way", bus.snp_hit_way, e.way);
                check("snp_rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.a_en = 0; bus.a_wen = 0; bus.a_way = 0; bus.a_idx = 0; bus.a_wdata = 0;
        bus.b_en = 0; bus.b_way = 0; bus.b_idx = 0; bus.b_wdata = 0;
        bus.snp_valid = 0; bus.snp_inv = 0; bus.snp_idx = 0; bus.snp_tag = 0;
    endtask

    task automatic write_a(input int way, input int idx, input logic [ENT_W-1:0] d);
        bus.a_en = 1; bus.a_wen = 1; bus.a_way = 1'(way); bus.a_idx = 9'(idx); bus.a_wdata = d;
        tick();
        bus.a_en = 0; bus.a_wen = 0;
    endtask

    task automatic write_b(input int way, input int idx, input logic [ENT_W-1:0] d);
        bus.b_en = 1; bus.b_way = 1'(way); bus.b_idx = 9'(idx); bus.b_wdata = d;
        tick();
        bus.b_en = 0;
    endtask

    task automatic read_a(input int idx, input logic [RD_W-1:0] req);
        bus.a_en = 1; bus.a_wen = 0; bus.a_idx = 9'(idx);
        rd_q.push_back(req);
        tick();
        bus.a_en = 0;
    endtask

    // Presents a snoop, waits (bounded) for ready, queues the expected response two cycles after accept.
    task automatic snoop(input logic inv, input int idx, input logic [TAG_W-1:0] tag,
                         input logic hit, input logic [1:0] way, output int waits);
        snp_exp_t e;
        bus.snp_valid = 1; bus.snp_inv = inv; bus.snp_idx = 9'(idx); bus.snp_tag = tag;
        waits = 0;
        while (!bus.snp_ready && waits < 20) begin
            tick();
            waits++;
        end
        if (!bus.snp_ready) check("snp_ready_timeout", 0, 1);
        else begin
            e.hit = hit; e.way = way; e.cyc = cyc + 2;
            snp_q.push_back(e);
        end
        tick();
        bus.snp_valid = 0;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!bus.init_done && n < LINES + 20) begin
            @(posedge clk); #1; n++;
        end
        check(name, n, LINES);
        tick();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int w;
        int n;
        snp_exp_t e;
        idle();
        rst = 1;
        repeat (3) tick();
        check("rst_init_done", bus.init_done, 0);
        check("rst_snp_ready", bus.snp_ready, 0);
        check("rst_rsp_valid", bus.snp_rsp_valid, 0);
        check("rst_snp_hit", bus.snp_hit, 0);
        check("rst_hit_way", bus.snp_hit_way, 0);
        check("rst_a_rdata", bus.a_rdata, 0);
`ifdef SNOOP_TAG_BANK_STATS_EN
        check("rst_stat_snp", stat_snp_cnt, 0);
        check("rst_stat_inv", stat_inv_cnt, 0);
`endif
        rst = 0;
        wait_init("init_cycles");
        read_a(5, '0);

        // Fill then invalidating snoop.
        write_b(1, 7, {1'b1, 20'h12345});
        snoop(1, 7, 20'h12345, 1'b1, 2'b10, w);
        repeat (3) tick();
        read_a(7, {1'b0, 20'h12345, 21'h0});
`ifdef SNOOP_TAG_BANK_STATS_EN
        check("stat_snp_after_inv", stat_snp_cnt, 1);
        check("stat_inv_after_inv", stat_inv_cnt, 1);
`endif

        // Probe hit leaves entry valid; mismatched tag misses.
        write_a(0, 20, {1'b1, 20'hABCDE});
        snoop(0, 20, 20'hABCDE, 1'b1, 2'b01, w);
        snoop(0, 20, 20'h11111, 1'b0, 2'b00, w);
        repeat (3) tick();
        read_a(20, {21'h0, 1'b1, 20'hABCDE});

        // Fill in the S1 cycle of a probe to the same set is seen by the compare.
        bus.snp_valid = 1; bus.snp_inv = 0; bus.snp_idx = 9; bus.snp_tag = 20'h0009A;
        check("fwd_ready", bus.snp_ready, 1);
        e.hit = 1; e.way = 2'b01; e.cyc = cyc + 2;
        snp_q.push_back(e);
        tick();
        bus.snp_valid = 0;
        write_b(0, 9, {1'b1, 20'h0009A});
        repeat (2) tick();

        // Core write during the S2 invalidate of the same entry wins.
        write_b(0, 11, {1'b1, 20'h0AAAA});
        bus.snp_valid = 1; bus.snp_inv = 1; bus.snp_idx = 11; bus.snp_tag = 20'h0AAAA;
        e.hit = 1; e.way = 2'b01; e.cyc = cyc + 2;
        snp_q.push_back(e);
        tick();
        bus.snp_valid = 0;
        tick();
        write_a(0, 11, {1'b1, 20'h0BBBB});
        repeat (2) tick();
        read_a(11, {21'h0, 1'b1, 20'h0BBBB});
`ifdef SNOOP_TAG_BANK_STATS_EN
        check("stat_inv_dropped", stat_inv_cnt, 1);
`endif

        // Back-to-back probes, then an invalidate stalls the following snoop one cycle.
        snoop(0, 20, 20'hABCDE, 1'b1, 2'b01, w); check("b2b_wait0", w, 0);
        snoop(0, 7,  20'h12345, 1'b0, 2'b00, w); check("b2b_wait1", w, 0);
        snoop(0, 9,  20'h0009A, 1'b1, 2'b01, w); check("b2b_wait2", w, 0);
        snoop(0, 11, 20'h0BBBB, 1'b1, 2'b01, w); check("b2b_wait3", w, 0);
        snoop(1, 30, 20'h00030, 1'b0, 2'b00, w); check("inv_wait", w, 0);
        snoop(0, 30, 20'h00030, 1'b0, 2'b00, w); check("after_inv_wait", w, 1);
        repeat (4) tick();

        // Reset at sweep index 200 restarts the full sweep; traffic during INIT is ignored.
        write_b(0, 5, {1'b1, 20'h55555});
        rst = 1;
        tick();
        rst = 0;
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1; n++;
        end
        rst = 1;
        #1;
        check("midsweep_init_done", bus.init_done, 0);
        tick();
        rst = 0;
        n = 0;
        while (!bus.init_done && n < LINES + 20) begin
            @(posedge clk); #1; n++;
            if (n == 300) begin
                bus.a_en = 1; bus.a_wen = 1; bus.a_way = 0; bus.a_idx = 2; bus.a_wdata = {1'b1, 20'h22222};
                bus.snp_valid = 1; bus.snp_inv = 0; bus.snp_idx = 2; bus.snp_tag = 20'h22222;
                check("init_snp_ready", bus.snp_ready, 0);
            end else if (n == 301) begin
                idle();
            end
        end
        check("restart_cycles", n, LINES);
        tick();
        read_a(5, '0);
        read_a(2, '0);
`ifdef SNOOP_TAG_BANK_STATS_EN
        check("stat_snp_after_rst", stat_snp_cnt, 0);
        check("stat_inv_after_rst", stat_inv_cnt, 0);
`endif
        repeat (4) tick();
        check("rd_q_empty", rd_q.size(), 0);
        check("snp_q_empty", snp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
